// File: rtl/sram_access_sequencer.sv
// sram_access_sequencer: takes one request at a time from the core and turns it
// into a registered, one-hot strobe for the SRAM control block. The strobe is held
// for ACCESS_CYCLES whole clock periods, so the SRAM controller sees both clock
// phases of every access.
// This block also owns the 8-entry hardware stack pointer (SRAM words 8-15) and
// reports full/empty.
module sram_access_sequencer #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       req_valid,
  input  logic [2:0] req_op,
  input  logic [1:0] req_r1_sel,
  output logic       req_ready,
  output logic [1:0] R1_addr,
  output logic [2:0] SP_addr,
  output logic       R1_IN,
  output logic       R1_OUT,
  output logic       Stack_IN,
  output logic       Stack_OUT,
  output logic       RA_IN,
  output logic       RA_OUT,
  output logic       done,
  output logic       err,
  output logic       full,
  output logic       empty
);

  // Operation encodings; the op value doubles as the strobe bit index.
  localparam logic [2:0] OP_R1_WR = 3'd0;
  localparam logic [2:0] OP_R1_RD = 3'd1;
  localparam logic [2:0] OP_PUSH  = 3'd2;
  localparam logic [2:0] OP_POP   = 3'd3;
  localparam logic [2:0] OP_RA_RD = 3'd5;

  localparam logic [3:0] STACK_DEPTH = 4'd8;

  // Clamp out-of-range settings into 1..15, so the down-counter always fits in 4 bits.
  localparam int unsigned CYCLES_CLAMPED =
    (ACCESS_CYCLES < 1) ? 1 : ((ACCESS_CYCLES > 15) ? 15 : ACCESS_CYCLES);
  localparam logic [3:0] CNT_LOAD = 4'(CYCLES_CLAMPED - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic       err_pending_q, err_pending_d;
  logic [3:0] sp_count_q, sp_count_d;
  logic [5:0] strobe_q, strobe_d;
  logic [1:0] r1_addr_q, r1_addr_d;
  logic [2:0] sp_addr_q, sp_addr_d;

  logic       req_illegal;
  logic [3:0] sp_count_minus1;

  assign sp_count_minus1 = sp_count_q - 4'd1;

  // Classify the incoming request. Illegal cases are an unknown op, a push onto
  // a full stack, and a pop from an empty stack.
  always_comb begin
    req_illegal = 1'b0;
    if (req_op > OP_RA_RD) begin
      req_illegal = 1'b1;
    end else if ((req_op == OP_PUSH) && (sp_count_q == STACK_DEPTH)) begin
      req_illegal = 1'b1;
    end else if ((req_op == OP_POP) && (sp_count_q == 4'd0)) begin
      req_illegal = 1'b1;
    end
  end

  // Next-state logic, and next values for the registered strobes and addresses.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    err_pending_d = err_pending_q;
    sp_count_d    = sp_count_q;
    strobe_d      = strobe_q;
    r1_addr_d     = r1_addr_q;
    sp_addr_d     = sp_addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d = req_op;
          if (req_illegal) begin
            // Rejected request: no strobe, straight to the completion cycle.
            err_pending_d = 1'b1;
            state_d       = ST_DONE;
          end else begin
            err_pending_d = 1'b0;
            state_d       = ST_ACCESS;
            cnt_d         = CNT_LOAD;
            strobe_d      = 6'b000001 << req_op;
            r1_addr_d     = ((req_op == OP_R1_WR) || (req_op == OP_R1_RD)) ? req_r1_sel : 2'd0;
            if (req_op == OP_PUSH) begin
              sp_addr_d = sp_count_q[2:0];
            end else if (req_op == OP_POP) begin
              sp_addr_d = sp_count_minus1[2:0];
            end else begin
              sp_addr_d = 3'd0;
            end
          end
        end
      end

      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d   = ST_DONE;
          strobe_d  = 6'b000000;
          r1_addr_d = 2'd0;
          sp_addr_d = 3'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_DONE: begin
        // The stack pointer moves only after a successful stack access.
        state_d       = ST_IDLE;
        err_pending_d = 1'b0;
        if (!err_pending_q) begin
          if (op_q == OP_PUSH) begin
            sp_count_d = sp_count_q + 4'd1;
          end else if (op_q == OP_POP) begin
            sp_count_d = sp_count_minus1;
          end
        end
      end

      default: begin
        state_d  = ST_IDLE;
        strobe_d = 6'b000000;
      end
    endcase
  end

  // State, counter and output registers. Reset drops the strobes at once and
  // abandons any access that is in flight.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 4'd0;
      op_q          <= OP_R1_WR;
      err_pending_q <= 1'b0;
      sp_count_q    <= 4'd0;
      strobe_q      <= 6'b000000;
      r1_addr_q     <= 2'd0;
      sp_addr_q     <= 3'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      err_pending_q <= err_pending_d;
      sp_count_q    <= sp_count_d;
      strobe_q      <= strobe_d;
      r1_addr_q     <= r1_addr_d;
      sp_addr_q     <= sp_addr_d;
    end
  end

  assign R1_IN     = strobe_q[0];
  assign R1_OUT    = strobe_q[1];
  assign Stack_IN  = strobe_q[2];
  assign Stack_OUT = strobe_q[3];
  assign RA_IN     = strobe_q[4];
  assign RA_OUT    = strobe_q[5];

  assign R1_addr   = r1_addr_q;
  assign SP_addr   = sp_addr_q;

  assign req_ready = (state_q == ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_DONE) && err_pending_q;

  assign full      = (sp_count_q == STACK_DEPTH);
  assign empty     = (sp_count_q == 4'd0);

endmodule
